// File: rtl/chiplet_types_pkg.sv
// Shared types for the chiplet switch datapath and its per-port credit tracking.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package chiplet_types_pkg;

   localparam int PKG_NUM_VCS     = 2;
   localparam int PKG_MAX_CREDITS = 8;
   localparam int PKG_VC_W        = (PKG_NUM_VCS > 1) ? $clog2(PKG_NUM_VCS) : 1;
   localparam int PKG_CREDIT_W    = $clog2(PKG_MAX_CREDITS + 1);

   // Packet-progress state of one virtual channel
   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } vc_state_e;

   // One VC's credit counter, wide enough to hold 0..MAX inclusive
   typedef logic [PKG_CREDIT_W-1:0] credit_cnt_t;

endpackage

// File: rtl/vc_credit_counter.sv
// Single-VC saturating credit counter with packet FSM and sticky error bits.
// Latency: 1 cycle from send/return to cnt/granted/busy.
// Backpressure: none; granted drops the cycle after the last credit is spent.
// Error bits are only built when OUTPUT_CREDIT_TRACKER_ERR_EN is defined.
module vc_credit_counter
   import chiplet_types_pkg::*;
#(
   parameter int MAX_CREDITS = PKG_MAX_CREDITS,
   parameter int CREDIT_W    = $clog2(MAX_CREDITS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                send,
   input  logic                last,
   input  logic                ret,
   output logic [CREDIT_W-1:0] cnt,
   output logic                granted,
   output logic                busy,
   output logic                underflow,
   output logic                overflow
);

   localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(MAX_CREDITS);

   vc_state_e           state;
   logic [CREDIT_W-1:0] cnt_nxt;
   logic                uf_evt;
   logic                of_evt;

   // Next count: a send and a return in the same cycle cancel; otherwise saturate at 0 / FULL
   always_comb begin
      cnt_nxt = cnt;
      uf_evt  = 1'b0;
      of_evt  = 1'b0;
      if (send && !ret) begin
         if (cnt == '0) uf_evt  = 1'b1;
         else           cnt_nxt = cnt - CREDIT_W'(1);
      end else if (ret && !send) begin
         if (cnt == FULL) of_evt  = 1'b1;
         else             cnt_nxt = cnt + CREDIT_W'(1);
      end
   end

   // Counter and grant; grant reflects the count being loaded so it never lags a spend
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= FULL;
         granted <= 1'b1;
      end else begin
         cnt     <= cnt_nxt;
         granted <= (cnt_nxt != '0);
      end
   end

   // Packet FSM: a non-tail send opens the VC, a tail send closes it
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (send && !last) begin
                  state <= ACTIVE;
                  busy  <= 1'b1;
               end
            end
            ACTIVE: begin
               if (send && last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef OUTPUT_CREDIT_TRACKER_ERR_EN
   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         underflow <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (uf_evt) underflow <= 1'b1;
         if (of_evt) overflow  <= 1'b1;
      end
   end
`else
   logic unused_err_evt;
   assign unused_err_evt = uf_evt | of_evt;
   assign underflow      = 1'b0;
   assign overflow       = 1'b0;
`endif

endmodule

// File: rtl/output_credit_tracker.sv
// Per-output-port credit and packet-progress tracker feeding grants back to the switch.
// Latency: 1 cycle; every output is registered, inputs at edge t show in cycle t+1.
// Backpressure: credit_granted[v] deasserts when VC v has no downstream slot left.
// Optional error detection: OUTPUT_CREDIT_TRACKER_ERR_EN (undefined ties both flags to 0).
module output_credit_tracker
   import chiplet_types_pkg::*;
#(
   parameter int NUM_VCS     = PKG_NUM_VCS,
   parameter int MAX_CREDITS = PKG_MAX_CREDITS,
   parameter int VC_W        = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
   parameter int CREDIT_W    = $clog2(MAX_CREDITS + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flit_valid,
   input  logic [VC_W-1:0]             flit_vc,
   input  logic                        flit_last,
   input  logic [NUM_VCS-1:0]          credit_return,
   output logic [NUM_VCS-1:0]          credit_granted,
   output logic [NUM_VCS-1:0]          vc_busy,
   output logic                        packet_sent,
   output logic [NUM_VCS*CREDIT_W-1:0] credit_count,
   output logic                        underflow_err,
   output logic                        overflow_err
);

   localparam int unsigned NV = NUM_VCS;

   logic               vc_ok;
   logic [NUM_VCS-1:0] send_vld;
   logic [NUM_VCS-1:0] uf_vec;
   logic [NUM_VCS-1:0] of_vec;
   logic               oob_err;

   // A flit on a VC index beyond the link is dropped entirely
   assign vc_ok = (32'(flit_vc) < NV);

   for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
      assign send_vld[v] = flit_valid && vc_ok && (flit_vc == VC_W'(v));

      vc_credit_counter #(
         .MAX_CREDITS (MAX_CREDITS),
         .CREDIT_W    (CREDIT_W)
      ) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .send      (send_vld[v]),
         .last      (flit_last),
         .ret       (credit_return[v]),
         .cnt       (credit_count[v*CREDIT_W +: CREDIT_W]),
         .granted   (credit_granted[v]),
         .busy      (vc_busy[v]),
         .underflow (uf_vec[v]),
         .overflow  (of_vec[v])
      );
   end

   // One pulse per accepted tail, so back-to-back tails give back-to-back pulses
   always_ff @(posedge clk) begin
      if (rst) packet_sent <= 1'b0;
      else     packet_sent <= flit_valid && flit_last && vc_ok;
   end

`ifdef OUTPUT_CREDIT_TRACKER_ERR_EN
   // Sticky flag for a flit addressed to a nonexistent VC
   always_ff @(posedge clk) begin
      if (rst)                      oob_err <= 1'b0;
      else if (flit_valid && !vc_ok) oob_err <= 1'b1;
   end
`else
   assign oob_err = 1'b0;
`endif

   assign underflow_err = |uf_vec;
   assign overflow_err  = (|of_vec) | oob_err;

endmodule
